// File: rtl/apb_master_bridge.sv
// Purpose : bridges a valid/ready command stream onto an APB4 master port, one transfer at a time.
// Latency : accept -> SETUP -> ACCESS (1 + wait states) -> RESP; zero-wait is 3 cycles to rsp_valid.
// Backpressure: cmd_ready only in IDLE; the response is held in RESP until rsp_ready.
//
// Ports:
//   PCLK, PRESET                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_write/addr/wdata/strb/prot are the payload
//   rsp_valid/rsp_ready          response handshake; rsp_rdata/rsp_slverr/rsp_timeout are the payload
//   PSEL..PPROT                  APB master outputs, all registered or decoded from state
//   PRDATA, PREADY, PSLVERR      APB completer inputs, only sampled in ACCESS
module apb_master_bridge #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_strb,
   input  logic [2:0]  cmd_prot,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_slverr,
   output logic        rsp_timeout,
   output logic        PSEL,
   output logic        PENABLE,
   output logic [31:0] PADDR,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   output logic [3:0]  PSTRB,
   output logic [2:0]  PPROT,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   // Counter is at least 9 bits so the default TIMEOUT=256 fits with headroom.
   localparam int CW = ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;
   localparam bit TMO_EN = (TIMEOUT != 0);
   localparam logic [CW-1:0] CNT_LAST = TMO_EN ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] wait_cnt;
   logic          accept;
   logic          timeout_hit;

   assign accept = cmd_valid && cmd_ready;

   // Abort on the TIMEOUT-th consecutive ACCESS cycle without PREADY; a
   // PREADY on that same cycle is a normal completion instead.
   assign timeout_hit = TMO_EN && !PREADY && (wait_cnt == CNT_LAST);

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            // Gated by PRESET so nothing is accepted on the reset edge itself.
            cmd_ready = !PRESET;
            if (cmd_valid && !PRESET) begin
               state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            PSEL      = 1'b1;
            state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            if (PREADY || timeout_hit) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         PADDR       <= '0;
         PWRITE      <= 1'b0;
         PWDATA      <= '0;
         PSTRB       <= '0;
         PPROT       <= '0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         if (accept) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PPROT  <= cmd_prot;
            // Reads carry no write data and no strobes on the bus.
            PWDATA <= cmd_write ? cmd_wdata : 32'h0;
            PSTRB  <= cmd_write ? cmd_strb : 4'h0;
         end

         if (state == S_SETUP) begin
            wait_cnt <= '0;
         end else if (state == S_ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + CW'(1);
         end

         // Response fields only move on the ACCESS exit edge, so they stay
         // frozen for the whole RESP phase regardless of the bus inputs.
         if (state == S_ACCESS) begin
            if (PREADY) begin
               rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
               rsp_slverr  <= PSLVERR;
               rsp_timeout <= 1'b0;
            end else if (timeout_hit) begin
               rsp_rdata   <= 32'h0;
               rsp_slverr  <= 1'b1;
               rsp_timeout <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose : self-checking bench for apb_master_bridge (TIMEOUT=4 instance plus TIMEOUT=0 instance).
// Latency : outputs sampled on the falling edge; cycle 0 is the cycle the command is accepted in.
// Backpressure: response consumer holds rsp_ready low for a per-transfer number of cycles.
module tb_apb_master_bridge;

   localparam int TMO_A = 4;

   logic PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   logic rst, hold_a, hold_b, rst_a, rst_b;
   assign rst_a = rst | hold_a;
   assign rst_b = rst | hold_b;

   // Shared stimulus
   logic        cmd_valid, cmd_write, rsp_ready;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic [2:0]  cmd_prot;
   logic [31:0] prdata;
   logic        pready, pslverr;

   // Instance A outputs
   logic        a_cmd_ready, a_rsp_valid, a_rsp_slverr, a_rsp_timeout;
   logic [31:0] a_rsp_rdata, a_paddr, a_pwdata;
   logic        a_psel, a_penable, a_pwrite;
   logic [3:0]  a_pstrb;
   logic [2:0]  a_pprot;
   // Instance B outputs
   logic        b_cmd_ready, b_rsp_valid, b_rsp_slverr, b_rsp_timeout;
   logic [31:0] b_rsp_rdata, b_paddr, b_pwdata;
   logic        b_psel, b_penable, b_pwrite;
   logic [3:0]  b_pstrb;
   logic [2:0]  b_pprot;

   apb_master_bridge #(.TIMEOUT(TMO_A)) dut_a (
      .PCLK(PCLK), .PRESET(rst_a),
      .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
      .rsp_slverr(a_rsp_slverr), .rsp_timeout(a_rsp_timeout),
      .PSEL(a_psel), .PENABLE(a_penable), .PADDR(a_paddr), .PWRITE(a_pwrite),
      .PWDATA(a_pwdata), .PSTRB(a_pstrb), .PPROT(a_pprot),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   apb_master_bridge #(.TIMEOUT(0)) dut_b (
      .PCLK(PCLK), .PRESET(rst_b),
      .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
      .rsp_slverr(b_rsp_slverr), .rsp_timeout(b_rsp_timeout),
      .PSEL(b_psel), .PENABLE(b_penable), .PADDR(b_paddr), .PWRITE(b_pwrite),
      .PWDATA(b_pwdata), .PSTRB(b_pstrb), .PPROT(b_pprot),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   // Completer model: ready on ACCESS cycle number slv_wait (0-based), noise otherwise.
   int          slv_wait;
   int          acc_cnt;
   logic [31:0] slv_rdata;
   logic        slv_err, slv_nerr, force_ready;

   always @(negedge PCLK) begin
      if ((a_psel && a_penable) || (b_psel && b_penable)) begin
         pready  = (acc_cnt == slv_wait);
         prdata  = pready ? slv_rdata : $urandom;
         pslverr = pready ? slv_err : slv_nerr;
         acc_cnt = acc_cnt + 1;
      end else begin
         acc_cnt = 0;
         pready  = force_ready;
         prdata  = $urandom;
         pslverr = 1'($urandom_range(0, 1));
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;
      logic [31:0] rdata;
      logic        err;
      logic        nerr;
      int          hold;
      logic        pulse;
      int          e_lat;
      int          e_acc;
      logic [31:0] e_rdata;
      logic        e_err;
      logic        e_tmo;
   } vec_t;

   // One complete transfer on instance A, entered and left on a falling edge.
   task automatic do_xfer(input string tag, input vec_t v);
      int          cyc;
      int          acc;
      bit          stable;
      bit          hold_ok;
      logic [34:0] snap;
      slv_wait  = v.waits;
      slv_rdata = v.rdata;
      slv_err   = v.err;
      slv_nerr  = v.nerr;
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_strb  = v.strb;
      cmd_prot  = v.prot;
      cyc = 0;
      while (a_cmd_ready !== 1'b1 && cyc < 50) begin
         @(negedge PCLK);
         cyc++;
      end
      chk({tag, ":accept"}, 32'(a_cmd_ready), 32'd1);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      chk({tag, ":setup"}, {a_psel, a_penable}, 32'b10);
      chk({tag, ":paddr"}, a_paddr, v.addr);
      chk({tag, ":pwrite"}, 32'(a_pwrite), 32'(v.wr));
      chk({tag, ":pwdata"}, a_pwdata, v.wr ? v.wdata : 32'h0);
      chk({tag, ":pstrb"}, 32'(a_pstrb), v.wr ? 32'(v.strb) : 32'h0);
      chk({tag, ":pprot"}, 32'(a_pprot), 32'(v.prot));
      cyc = 1;
      acc = 0;
      stable = 1'b1;
      while (a_rsp_valid !== 1'b1 && cyc < 3000) begin
         @(negedge PCLK);
         cyc++;
         if (a_penable) acc++;
         if (a_psel && (a_paddr !== v.addr || a_pwrite !== v.wr || a_pprot !== v.prot ||
                        a_pwdata !== (v.wr ? v.wdata : 32'h0) ||
                        a_pstrb !== (v.wr ? v.strb : 4'h0))) stable = 1'b0;
      end
      chk({tag, ":latency"}, cyc, v.e_lat);
      chk({tag, ":access_cycles"}, acc, v.e_acc);
      chk({tag, ":apb_stable"}, 32'(stable), 32'd1);
      chk({tag, ":psel_in_resp"}, {a_psel, a_penable}, 32'b00);
      chk({tag, ":rdata"}, a_rsp_rdata, v.e_rdata);
      chk({tag, ":slverr"}, 32'(a_rsp_slverr), 32'(v.e_err));
      chk({tag, ":timeout"}, 32'(a_rsp_timeout), 32'(v.e_tmo));
      snap = {a_rsp_rdata, a_rsp_slverr, a_rsp_timeout, a_rsp_valid};
      hold_ok = 1'b1;
      force_ready = v.pulse;
      for (int i = 0; i < v.hold; i++) begin
         @(negedge PCLK);
         if (a_cmd_ready !== 1'b0 ||
             {a_rsp_rdata, a_rsp_slverr, a_rsp_timeout, a_rsp_valid} !== snap) hold_ok = 1'b0;
      end
      chk({tag, ":rsp_hold"}, 32'(hold_ok), 32'd1);
      force_ready = 1'b0;
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      chk({tag, ":rsp_drop"}, 32'(a_rsp_valid), 32'd0);
   endtask

   vec_t tbl[7];

   initial begin
      int          cyc;
      int          acc;
      bit          ok_rdy;
      bit          ok_st;
      logic [34:0] snap;
      vec_t        v;

      //        wr    addr          wdata         strb     prot    w   rdata         err   nerr  hold pulse lat acc e_rdata       e_err e_tmo
      tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0110, 3'b010, 0,  32'hFFFF_0000, 1'b0, 1'b0, 0, 1'b0, 3, 1, 32'h0,         1'b0, 1'b0};
      tbl[1] = '{1'b0, 32'h0000_0044, 32'h0,         4'b1111, 3'b000, 3,  32'h1234_5678, 1'b0, 1'b0, 2, 1'b0, 6, 4, 32'h1234_5678, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 32'h0000_0080, 32'h0,         4'b0000, 3'b001, 1,  32'hCAFE_F00D, 1'b1, 1'b1, 1, 1'b0, 4, 2, 32'hCAFE_F00D, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 3'b100, 10, 32'hAAAA_5555, 1'b0, 1'b1, 3, 1'b1, 6, 4, 32'h0,         1'b1, 1'b1};
      tbl[4] = '{1'b1, 32'h0000_0200, 32'h0102_0304, 4'b1001, 3'b111, 3,  32'h5555_AAAA, 1'b1, 1'b0, 0, 1'b0, 6, 4, 32'h0,         1'b1, 1'b0};
      tbl[5] = '{1'b0, 32'h0000_0204, 32'h0,         4'b0000, 3'b011, 4,  32'h7777_7777, 1'b0, 1'b0, 2, 1'b1, 6, 4, 32'h0,         1'b1, 1'b1};
      tbl[6] = '{1'b1, 32'hFFFF_FFFC, 32'h8000_0001, 4'b1111, 3'b101, 0,  32'h9999_9999, 1'b0, 1'b1, 1, 1'b0, 3, 1, 32'h0,         1'b0, 1'b0};

      rst = 1'b1; hold_a = 1'b0; hold_b = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
      rsp_ready = 1'b0; force_ready = 1'b0;
      slv_wait = 0; slv_rdata = '0; slv_err = 1'b0; slv_nerr = 1'b0;

      // Reset values
      repeat (3) @(negedge PCLK);
      chk("rst_a_ctrl", {a_psel, a_penable, a_pwrite, a_pstrb, a_pprot, a_rsp_valid,
                         a_rsp_slverr, a_rsp_timeout, a_cmd_ready}, 32'h0);
      chk("rst_a_paddr", a_paddr, 32'h0);
      chk("rst_a_pwdata", a_pwdata, 32'h0);
      chk("rst_a_rdata", a_rsp_rdata, 32'h0);
      chk("rst_b_ctrl", {b_psel, b_penable, b_pwrite, b_pstrb, b_pprot, b_rsp_valid,
                         b_rsp_slverr, b_rsp_timeout, b_cmd_ready}, 32'h0);
      chk("rst_b_data", b_paddr | b_pwdata | b_rsp_rdata, 32'h0);
      rst = 1'b0;
      @(negedge PCLK);
      chk("rst_release_ready", 32'(a_cmd_ready), 32'd1);

      // Directed vector table
      for (int i = 0; i < 7; i++) begin
         do_xfer($sformatf("tbl%0d", i), tbl[i]);
      end

      // Back-to-back: second command waits behind a stalled response
      slv_wait = 0; slv_rdata = 32'h1111_2222; slv_err = 1'b0; slv_nerr = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h400; cmd_wdata = '0; cmd_strb = '0; cmd_prot = 3'b000;
      @(negedge PCLK);
      cmd_write = 1'b1; cmd_addr = 32'h404; cmd_wdata = 32'h7777_8888; cmd_strb = 4'hF; cmd_prot = 3'b001;
      cyc = 0;
      while (a_rsp_valid !== 1'b1 && cyc < 20) begin
         @(negedge PCLK);
         cyc++;
      end
      chk("b2b_first_rdata", a_rsp_rdata, 32'h1111_2222);
      snap = {a_rsp_rdata, a_rsp_slverr, a_rsp_timeout, a_rsp_valid};
      ok_rdy = 1'b1;
      ok_st = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK);
         if (a_cmd_ready !== 1'b0) ok_rdy = 1'b0;
         if ({a_rsp_rdata, a_rsp_slverr, a_rsp_timeout, a_rsp_valid} !== snap) ok_st = 1'b0;
      end
      chk("b2b_cmd_ready_low", 32'(ok_rdy), 32'd1);
      chk("b2b_rsp_stable", 32'(ok_st), 32'd1);
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      chk("b2b_idle_after_hs", {a_psel, a_cmd_ready, a_rsp_valid}, 32'b010);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      chk("b2b_second_setup", {a_psel, a_penable}, 32'b10);
      chk("b2b_second_paddr", a_paddr, 32'h404);
      chk("b2b_second_pwdata", a_pwdata, 32'h7777_8888);
      cyc = 0;
      while (a_rsp_valid !== 1'b1 && cyc < 20) begin
         @(negedge PCLK);
         cyc++;
      end
      chk("b2b_second_rdata", a_rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;

      // Reset in the middle of a write ACCESS phase
      slv_wait = 3; slv_rdata = '0; slv_err = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_wdata = 32'h55; cmd_strb = 4'h3; cmd_prot = 3'b000;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      chk("prst_in_access", {a_psel, a_penable}, 32'b11);
      rst = 1'b1;
      @(negedge PCLK);
      chk("prst_outputs", {a_psel, a_penable, a_rsp_valid, a_cmd_ready}, 32'b0000);
      rst = 1'b0;
      @(negedge PCLK);
      chk("prst_ready_after", 32'(a_cmd_ready), 32'd1);
      ok_st = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge PCLK);
         if (a_rsp_valid !== 1'b0 || a_psel !== 1'b0) ok_st = 1'b0;
      end
      chk("prst_no_response", 32'(ok_st), 32'd1);

      // TIMEOUT=0 instance waits 1000 wait states without aborting
      hold_a = 1'b1; hold_b = 1'b0;
      @(negedge PCLK);
      chk("t0_ready", 32'(b_cmd_ready), 32'd1);
      slv_wait = 1000; slv_rdata = 32'h0BAD_CAFE; slv_err = 1'b0; slv_nerr = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h500;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      cyc = 1;
      acc = 0;
      while (b_rsp_valid !== 1'b1 && cyc < 1200) begin
         @(negedge PCLK);
         cyc++;
         if (b_penable) acc++;
      end
      chk("t0_latency", cyc, 32'd1003);
      chk("t0_access_cycles", acc, 32'd1001);
      chk("t0_timeout", 32'(b_rsp_timeout), 32'd0);
      chk("t0_slverr", 32'(b_rsp_slverr), 32'd0);
      chk("t0_rdata", b_rsp_rdata, 32'h0BAD_CAFE);
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      hold_b = 1'b1; hold_a = 1'b0;
      @(negedge PCLK);

      // Random transfers against a transaction-level model of instance A
      for (int n = 0; n < 40; n++) begin
         v.wr    = 1'($urandom_range(0, 1));
         v.addr  = $urandom;
         v.wdata = $urandom;
         v.strb  = 4'($urandom_range(0, 15));
         v.prot  = 3'($urandom_range(0, 7));
         v.waits = $urandom_range(0, 6);
         v.rdata = $urandom;
         v.err   = 1'($urandom_range(0, 1));
         v.nerr  = 1'($urandom_range(0, 1));
         v.hold  = $urandom_range(0, 3);
         v.pulse = 1'($urandom_range(0, 1));
         if (v.waits >= TMO_A) begin
            v.e_lat   = 2 + TMO_A;
            v.e_acc   = TMO_A;
            v.e_rdata = 32'h0;
            v.e_err   = 1'b1;
            v.e_tmo   = 1'b1;
         end else begin
            v.e_lat   = 3 + v.waits;
            v.e_acc   = v.waits + 1;
            v.e_rdata = v.wr ? 32'h0 : v.rdata;
            v.e_err   = v.err;
            v.e_tmo   = 1'b0;
         end
         do_xfer($sformatf("rnd%0d", n), v);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
